// File: rtl/fft_pkg.sv
// fft_pkg
// Shared constants and types for the FFT input packer slice.
//   DATA  : signed bits per real/imag component
//   ARRAY : parallel lanes per output vector
//   ROWS  : output vectors per frame
//   FRAME : samples per frame (ARRAY*ROWS)
// Also holds the sample/vector typedefs and the reader state enum.
package fft_pkg;

    localparam int DATA  = 9;
    localparam int ARRAY = 16;
    localparam int ROWS  = 32;
    localparam int FRAME = ARRAY * ROWS;

    typedef logic signed [DATA-1:0] sample_t;
    typedef sample_t [ARRAY-1:0]    vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fft_input_packer_if.sv
// fft_input_packer_if
// Serial complex-sample stream with valid/ready handshake.
//   s_valid : sample valid (master -> slave)
//   s_ready : slave can accept a sample (slave -> master)
//   s_re    : sample real part
//   s_im    : sample imaginary part
//   s_last  : last sample of the current frame
interface fft_input_packer_if;
    import fft_pkg::*;

    logic    s_valid;
    logic    s_ready;
    sample_t s_re;
    sample_t s_im;
    logic    s_last;

    modport master (output s_valid, s_re, s_im, s_last, input s_ready);
    modport slave  (input s_valid, s_re, s_im, s_last, output s_ready);

endinterface

// File: rtl/fft_frame_bank.sv
// fft_frame_bank
// One ping-pong storage bank of ROWS x ARRAY complex entries.
//   clk     : clock
//   we      : write one entry at (wr_row, wr_lane)
//   wr_row  : row of the entry being written
//   wr_lane : lane of the entry being written
//   wr_re   : real part to store
//   wr_im   : imaginary part to store
//   rd_row  : row presented on the read port
//   rd_re   : all lanes of rd_row, real parts
//   rd_im   : all lanes of rd_row, imaginary parts
// Storage has no reset; stale contents are masked by the fill count in the top.
module fft_frame_bank #(
    parameter int  DATA   = fft_pkg::DATA,
    parameter int  ARRAY  = fft_pkg::ARRAY,
    parameter int  ROWS   = fft_pkg::ROWS,
    localparam int LANE_W = $clog2(ARRAY),
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ROW_W-1:0]           wr_row,
    input  logic [LANE_W-1:0]          wr_lane,
    input  logic [DATA-1:0]            wr_re,
    input  logic [DATA-1:0]            wr_im,
    input  logic [ROW_W-1:0]           rd_row,
    output logic [ARRAY-1:0][DATA-1:0] rd_re,
    output logic [ARRAY-1:0][DATA-1:0] rd_im
);
    import fft_pkg::*;

    logic [ARRAY-1:0][DATA-1:0] mem_re [ROWS];
    logic [ARRAY-1:0][DATA-1:0] mem_im [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[wr_row][wr_lane] <= wr_re;
            mem_im[wr_row][wr_lane] <= wr_im;
        end
    end

    assign rd_re = mem_re[rd_row];
    assign rd_im = mem_im[rd_row];

endmodule

// File: rtl/fft_input_packer.sv
// fft_input_packer
// Packs a serial complex sample stream into ROWS parallel vectors of ARRAY
// lanes per frame, using two ping-pong banks (writer fills one while the
// reader bursts the other out).
//   clk       : clock, rising edge
//   rstn      : asynchronous active-low reset
//   s_if      : serial sample stream (slave side)
//   valid_out : parallel vector valid
//   din_re_t  : lane-indexed real vector
//   din_im_t  : lane-indexed imaginary vector
module fft_input_packer #(
    parameter int DATA  = fft_pkg::DATA,
    parameter int ARRAY = fft_pkg::ARRAY,
    parameter int ROWS  = fft_pkg::ROWS
) (
    input  logic                              clk,
    input  logic                              rstn,
    fft_input_packer_if.slave                 s_if,
    output logic                              valid_out,
    output logic signed [ARRAY-1:0][DATA-1:0] din_re_t,
    output logic signed [ARRAY-1:0][DATA-1:0] din_im_t
);
    import fft_pkg::*;

    localparam int NSAMP  = ARRAY * ROWS;
    localparam int LANE_W = $clog2(ARRAY);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = LANE_W + ROW_W;

    // Writer side
    logic             wr_bank, wr_bank_nxt;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [1:0]       full, full_nxt;
    logic [CNT_W:0]   fill [2];
    logic             ready_q, ready_nxt;
    logic             accept, close;

    // Reader side
    rd_state_t        state, state_nxt;
    logic             rd_bank, rd_bank_nxt;
    logic [ROW_W-1:0] rd_row, rd_row_nxt;
    logic             drain_done;
    logic [CNT_W:0]   lane_idx;

    logic [ARRAY-1:0][DATA-1:0] bank_re [2];
    logic [ARRAY-1:0][DATA-1:0] bank_im [2];

    assign s_if.s_ready = ready_q;
    assign accept       = s_if.s_valid && ready_q;
    assign close        = accept && (s_if.s_last || (wr_cnt == CNT_W'(NSAMP - 1)));

    fft_frame_bank #(.DATA(DATA), .ARRAY(ARRAY), .ROWS(ROWS)) u_bank0 (
        .clk     (clk),
        .we      (accept && !wr_bank),
        .wr_row  (wr_cnt[CNT_W-1:LANE_W]),
        .wr_lane (wr_cnt[LANE_W-1:0]),
        .wr_re   (s_if.s_re),
        .wr_im   (s_if.s_im),
        .rd_row  (rd_row),
        .rd_re   (bank_re[0]),
        .rd_im   (bank_im[0])
    );

    fft_frame_bank #(.DATA(DATA), .ARRAY(ARRAY), .ROWS(ROWS)) u_bank1 (
        .clk     (clk),
        .we      (accept && wr_bank),
        .wr_row  (wr_cnt[CNT_W-1:LANE_W]),
        .wr_lane (wr_cnt[LANE_W-1:0]),
        .wr_re   (s_if.s_re),
        .wr_im   (s_if.s_im),
        .rd_row  (rd_row),
        .rd_re   (bank_re[1]),
        .rd_im   (bank_im[1])
    );

    // Drain-complete and write-close always hit different banks, so both
    // updates apply in the same cycle. s_ready is precomputed from the
    // post-update flags so it is low exactly while the target bank is full.
    always_comb begin
        wr_bank_nxt = wr_bank;
        wr_cnt_nxt  = wr_cnt;
        full_nxt    = full;
        if (drain_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (close) begin
            full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt       = ~wr_bank;
            wr_cnt_nxt        = '0;
        end else if (accept) begin
            wr_cnt_nxt = wr_cnt + 1'b1;
        end
        ready_nxt = ~full_nxt[wr_bank_nxt];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            full    <= '0;
            ready_q <= 1'b0;
            fill[0] <= '0;
            fill[1] <= '0;
        end else begin
            wr_bank <= wr_bank_nxt;
            wr_cnt  <= wr_cnt_nxt;
            full    <= full_nxt;
            ready_q <= ready_nxt;
            if (close) begin
                fill[wr_bank] <= {1'b0, wr_cnt} + 1'b1;
            end
        end
    end

    // The writer alternates banks and so does the reader, so waiting on
    // rd_bank alone always drains the oldest full bank first.
    always_comb begin
        state_nxt   = state;
        rd_row_nxt  = rd_row;
        rd_bank_nxt = rd_bank;
        drain_done  = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt  = BURST;
                    rd_row_nxt = '0;
                end
            end
            BURST: begin
                if (rd_row == ROW_W'(ROWS - 1)) begin
                    state_nxt   = GAP;
                    drain_done  = 1'b1;
                    rd_bank_nxt = ~rd_bank;
                end else begin
                    rd_row_nxt = rd_row + 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_row  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_row  <= rd_row_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // Entries at or beyond the fill count hold stale data from earlier
    // frames; they are forced to zero here instead of clearing the bank.
    always_comb begin
        valid_out = (state == BURST);
        din_re_t  = '0;
        din_im_t  = '0;
        lane_idx  = '0;
        if (state == BURST) begin
            for (int j = 0; j < ARRAY; j++) begin
                lane_idx = {1'b0, rd_row, LANE_W'(j)};
                if (lane_idx < fill[rd_bank]) begin
                    din_re_t[j] = bank_re[rd_bank][j];
                    din_im_t[j] = bank_im[rd_bank][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_input_packer.sv
// tb_fft_input_packer
// Directed bench for fft_input_packer. Each frame's expected output rows are
// computed from the stimulus and queued when the frame is driven; a monitor
// pops and compares one row per valid_out cycle.
module tb_fft_input_packer;
    import fft_pkg::*;

    localparam int VW = ARRAY * DATA;

    typedef struct packed {
        logic [VW-1:0] re;
        logic [VW-1:0] im;
    } row_t;

    logic clk = 1'b0;
    logic rstn;
    logic valid_out;
    logic signed [ARRAY-1:0][DATA-1:0] din_re_t;
    logic signed [ARRAY-1:0][DATA-1:0] din_im_t;

    fft_input_packer_if sif ();

    fft_input_packer #(.DATA(DATA), .ARRAY(ARRAY), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_if      (sif),
        .valid_out (valid_out),
        .din_re_t  (din_re_t),
        .din_im_t  (din_im_t)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    row_t sb [$];
    logic [DATA-1:0] fr_re [FRAME];
    logic [DATA-1:0] fr_im [FRAME];
    int   run_len = 0;
    row_t mon_row;

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected rows of a frame of 'count' samples, zero padded past count.
    task automatic pushFrame(input int count);
        row_t rw;
        for (int r = 0; r < ROWS; r++) begin
            rw = '0;
            for (int j = 0; j < ARRAY; j++) begin
                if (r * ARRAY + j < count) begin
                    rw.re[j*DATA +: DATA] = fr_re[r*ARRAY + j];
                    rw.im[j*DATA +: DATA] = fr_im[r*ARRAY + j];
                end
            end
            sb.push_back(rw);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic sendSample(input logic [DATA-1:0] re, input logic [DATA-1:0] im,
                              input logic last, output int stalls);
        stalls = 0;
        sif.s_valid = 1'b1;
        sif.s_re    = re;
        sif.s_im    = im;
        sif.s_last  = last;
        while (sif.s_ready !== 1'b1 && stalls < 1000) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 1000) checkOutput("ready_wait", sif.s_ready, 1'b1);
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic applyStimulus(input int count, input bit use_last, input bit gaps, output int stalls);
        int st;
        int g;
        stalls = 0;
        pushFrame(count);
        for (int i = 0; i < count; i++) begin
            g = 0;
            while (gaps && $urandom_range(0, 1) == 1 && g < 8) begin
                sif.s_valid = 1'b0;
                sif.s_re    = DATA'($urandom);
                sif.s_im    = DATA'($urandom);
                @(negedge clk);
                g++;
            end
            sendSample(fr_re[i], fr_im[i], use_last && (i == count - 1), st);
            stalls += st;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || valid_out !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic setRamp();
        for (int n = 0; n < FRAME; n++) begin
            fr_re[n] = DATA'((n % 256) - 128);
            fr_im[n] = DATA'(128 - (n % 256));
        end
    endtask

    task automatic setRandom();
        for (int n = 0; n < FRAME; n++) begin
            fr_re[n] = DATA'($urandom);
            fr_im[n] = DATA'($urandom);
        end
    endtask

    // Monitor: one expected row per valid cycle, zero outputs otherwise.
    always @(negedge clk) begin
        if (rstn !== 1'b1) begin
            run_len = 0;
        end else if (valid_out === 1'b1) begin
            run_len++;
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", valid_out, 1'b0);
            end else begin
                mon_row = sb.pop_front();
                checkOutput("row_re", din_re_t, mon_row.re);
                checkOutput("row_im", din_im_t, mon_row.im);
            end
        end else begin
            if (run_len != 0) checkOutput("burst_len", run_len, ROWS);
            run_len = 0;
            checkOutput("idle_re", din_re_t, '0);
            checkOutput("idle_im", din_im_t, '0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int st;
        int n;

        rstn        = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_re    = '0;
        sif.s_im    = '0;
        sif.s_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", sif.s_ready, 1'b0);
        checkOutput("rst_valid", valid_out, 1'b0);
        checkOutput("rst_re", din_re_t, '0);
        checkOutput("rst_im", din_im_t, '0);
        rstn = 1'b1;
        #1;
        checkOutput("ready_before_edge", sif.s_ready, 1'b0);
        @(negedge clk);
        checkOutput("ready_rise", sif.s_ready, 1'b1);

        // Full ramp frame and first-output latency
        $display("[TB] ramp frame");
        setRamp();
        applyStimulus(FRAME, 1'b0, 1'b0, st);
        checkOutput("lat_early", valid_out, 1'b0);
        @(negedge clk);
        checkOutput("lat_first", valid_out, 1'b1);
        waitDrain();

        // Two frames back to back, continuous valid
        $display("[TB] back-to-back frames");
        setRandom();
        applyStimulus(FRAME, 1'b0, 1'b0, st);
        n = st;
        setRandom();
        applyStimulus(FRAME, 1'b1, 1'b0, st);
        checkOutput("b2b_stalls", n + st, 0);
        waitDrain();

        // Early close on sample 19
        $display("[TB] early close");
        for (int i = 0; i < 20; i++) begin
            fr_re[i] = DATA'(i + 1);
            fr_im[i] = DATA'(-(i + 1));
        end
        applyStimulus(20, 1'b1, 1'b0, st);
        waitDrain();

        // Three single-sample frames; the third must wait for a free bank
        $display("[TB] single-sample frames");
        fr_re[0] = DATA'(5);   fr_im[0] = DATA'(-5);
        applyStimulus(1, 1'b1, 1'b0, st);
        fr_re[0] = DATA'(-7);  fr_im[0] = DATA'(7);
        applyStimulus(1, 1'b1, 1'b0, st);
        fr_re[0] = DATA'(100); fr_im[0] = DATA'(-100);
        applyStimulus(1, 1'b1, 1'b0, st);
        checkOutput("third_stalled", st > 0, 1'b1);
        waitDrain();

        // Reset in the middle of a burst
        $display("[TB] reset mid-burst");
        setRamp();
        applyStimulus(FRAME, 1'b0, 1'b0, st);
        n = 0;
        while (valid_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("e_burst_start", valid_out, 1'b1);
        repeat (10) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("e_rst_valid", valid_out, 1'b0);
        checkOutput("e_rst_re", din_re_t, '0);
        checkOutput("e_rst_im", din_im_t, '0);
        checkOutput("e_rst_ready", sif.s_ready, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("e_ready_after", sif.s_ready, 1'b1);
        setRandom();
        applyStimulus(37, 1'b1, 1'b0, st);
        waitDrain();

        // Random valid gaps over three frames
        $display("[TB] random gaps");
        setRandom();
        applyStimulus(FRAME, 1'b0, 1'b1, st);
        setRandom();
        applyStimulus(300, 1'b1, 1'b1, st);
        setRandom();
        applyStimulus(FRAME, 1'b0, 1'b1, st);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_packer.md
FFT_INPUT_PACKER -- requirements
Module: fft_input_packer

Interface
REQ-001 The block SHALL have parameter DATA, default 9, giving the signed sample width per real/imag component.
REQ-002 The block SHALL have parameter ARRAY, default 16, giving the parallel lanes per output vector.
REQ-003 The block SHALL have parameter ROWS, default 32, giving the output vectors per frame (frame = ARRAY*ROWS = 512 samples).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 s_valid  input  1  serial sample valid.
REQ-007 s_ready  output  1  packer can accept a sample.
REQ-008 s_re  input  DATA signed  sample real part.
REQ-009 s_im  input  DATA signed  sample imaginary part.
REQ-010 s_last  input  1  last sample of frame (early close allowed).
REQ-011 valid_out  output  1  parallel vector valid; drives FFT valid_in.
REQ-012 din_re_t  output  ARRAY x DATA signed  lane-indexed real vector [ARRAY-1:0].
REQ-013 din_im_t  output  ARRAY x DATA signed  lane-indexed imaginary vector [ARRAY-1:0].

Function
REQ-014 A sample SHALL transfer only on a cycle where s_valid and s_ready are both 1.
REQ-015 The n-th accepted sample of a frame (n = 0..511) SHALL be stored at row n/ARRAY, lane n%ARRAY.
REQ-016 Storage SHALL be two ping-pong banks of ROWS x ARRAY complex entries; the writer fills one bank while the reader drains the other.
REQ-017 A frame SHALL close on the accepting cycle of sample 511, or on an accepting cycle with s_last=1, whichever comes first; s_last on sample 511 is a normal close.
REQ-018 On close, the bank SHALL be marked full with its fill count (1..512) and the writer SHALL switch to the other bank, starting at n=0.
REQ-019 s_ready SHALL be registered and SHALL be 0 exactly when the write-target bank is marked full; it must not depend combinationally on s_valid.
REQ-020 The reader FSM SHALL have states IDLE, BURST, GAP; IDLE->BURST when a full bank exists (oldest first); BURST->GAP after row ROWS-1; GAP->IDLE after one cycle.
REQ-021 In BURST, valid_out SHALL be 1 for exactly ROWS consecutive cycles, presenting rows 0..ROWS-1 in order, with lane j on din_*_t[j].
REQ-022 Entries with index >= fill count SHALL be output as 0 (zero padding); no clearing pass is required.
REQ-023 After the last BURST cycle the bank SHALL be marked empty, and valid_out SHALL be 0 for at least one cycle (GAP) between frames.
REQ-024 First valid_out SHALL occur on the 2nd rising edge after the closing handshake when the reader is IDLE (1 cycle register, 1 cycle FSM).
REQ-025 When valid_out is 0, din_re_t and din_im_t SHALL be driven to all zeros.
REQ-026 Simultaneous write-close of one bank and drain-complete of the other SHALL both take effect; s_ready SHALL stay 1 on the following cycle.
REQ-027 No sample SHALL ever be dropped or overwritten; backpressure is the only overflow mechanism.

Reset
REQ-028 While rstn=0: valid_out=0, s_ready=0, din_re_t/din_im_t=0, both banks empty, write pointer n=0 on bank 0, reader in IDLE.
REQ-029 s_ready SHALL rise on the first rising edge after rstn deasserts.
REQ-030 Reset mid-frame or mid-burst SHALL abort the operation; partial data is discarded and never output.

Structure
REQ-031 Package fft_pkg SHALL hold DATA, ARRAY, ROWS, FRAME=ARRAY*ROWS, the sample/vector typedefs and the reader state enum.
REQ-032 A sub-module fft_frame_bank SHALL implement one bank: a lane-addressed single-entry write port and a full-row read port; instantiate it twice.

Verification
REQ-033 512 samples re=n mod 256-128, im=-re, s_valid held 1 -> 32 cycles valid_out; cycle r lane j = (16r+j) mod 256-128; first valid_out 2 edges after sample 511.
REQ-034 Two full frames back-to-back, s_valid continuous -> s_ready never drops; bursts separated by >= 1 idle cycle; both frames bit-exact.
REQ-035 s_last on sample 19 (values 1..20) -> row0 lanes 0..15 = 1..16, row1 lanes 0..3 = 17..20, all other lanes and rows 0; still 32 valid cycles.
REQ-036 Three 1-sample frames (s_last each) -> third sample stalls (s_ready=0) until first burst ends; three bursts of 32 cycles, each value at row0 lane0.
REQ-037 rstn pulled low at burst row 10 -> valid_out and outputs 0 immediately (async); after release no residual output; a new frame packs correctly.
REQ-038 Random s_valid gaps (50%) over 3 frames -> output identical to gap-free run; no sample lost or duplicated.
